// File: rtl/fadd_pipe.sv
// Pipelined floating-point adder/subtractor: input register, unpack/align,
// add/normalise, round/pack. Valid/ready handshake with per-stage stalling.
module fadd_pipe #(
    parameter int EXPWIDTH  = 8,
    parameter int PRECISION = 24,
    parameter int TAGW      = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [EXPWIDTH+PRECISION-1:0]   a_i,
    input  logic [EXPWIDTH+PRECISION-1:0]   b_i,
    input  logic                            sub_i,
    input  logic [2:0]                      RM_i,
    input  logic [TAGW-1:0]                 tag_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [EXPWIDTH+PRECISION-1:0]   result_o,
    output logic [4:0]                      fflags_o,
    output logic [TAGW-1:0]                 tag_o
);

    localparam int E   = EXPWIDTH;
    localparam int P   = PRECISION;
    localparam int W   = E + P;
    localparam int F   = P - 1;
    localparam int N   = P + 3;
    localparam int SHW = $clog2(N + 1);
    localparam int CW  = ((E > SHW) ? E : SHW) + 1;

    localparam logic [E-1:0] EXP_ONES = '1;
    localparam logic [E:0]   N_E      = (E+1)'(N);
    localparam logic [W-1:0] QNAN     = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    // A stage loads whenever it is empty or its content moves on this edge.
    logic w_en1, w_en2, w_en3, w_en_o;
    logic r1_v, r2_v, r3_v, r_out_v;

    assign w_en_o     = !r_out_v || out_ready_i;
    assign w_en3      = !r3_v || w_en_o;
    assign w_en2      = !r2_v || w_en3;
    assign w_en1      = !r1_v || w_en2;
    assign in_ready_o = w_en1;

    // ---------------- input register ----------------
    logic [W-1:0]    r1_a, r1_b;
    logic            r1_sub;
    logic [2:0]      r1_rm;
    logic [TAGW-1:0] r1_tag;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r1_v   <= 1'b0;
            r1_a   <= '0;
            r1_b   <= '0;
            r1_sub <= 1'b0;
            r1_rm  <= '0;
            r1_tag <= '0;
        end else if (w_en1) begin
            r1_v <= in_valid_i;
            if (in_valid_i) begin
                r1_a   <= a_i;
                r1_b   <= b_i;
                r1_sub <= sub_i;
                r1_rm  <= RM_i;
                r1_tag <= tag_i;
            end
        end
    end

    // ---------------- S1: unpack, specials, swap, align ----------------
    logic           w_sa, w_sb, w_sx, w_a_ge, w_eff_sub, w_near;
    logic [E-1:0]   w_ea, w_eb, w_eam, w_ebm, w_ex, w_ey, w_d;
    logic [F-1:0]   w_fa, w_fb;
    logic [P-1:0]   w_ma, w_mb, w_mx, w_my;
    logic           w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf;
    logic           w_spec1, w_spec_nv1;
    logic [W-1:0]   w_spec_res1;
    logic [SHW-1:0] w_sh;
    logic [2*N-1:0] w_wide;
    logic [N-1:0]   w_my_al;
    logic [2:0]     w_rm1;

    always_comb begin
        w_sa     = r1_a[W-1];
        w_sb     = r1_b[W-1] ^ r1_sub;
        w_ea     = r1_a[W-2:F];
        w_eb     = r1_b[W-2:F];
        w_fa     = r1_a[F-1:0];
        w_fb     = r1_b[F-1:0];
        w_a_nan  = (w_ea == EXP_ONES) && (w_fa != '0);
        w_b_nan  = (w_eb == EXP_ONES) && (w_fb != '0);
        w_a_snan = w_a_nan && !w_fa[F-1];
        w_b_snan = w_b_nan && !w_fb[F-1];
        w_a_inf  = (w_ea == EXP_ONES) && (w_fa == '0);
        w_b_inf  = (w_eb == EXP_ONES) && (w_fb == '0);
        w_rm1    = (r1_rm > RM_RMM) ? RM_RNE : r1_rm;

        w_spec1     = w_a_nan || w_b_nan || w_a_inf || w_b_inf;
        w_spec_nv1  = 1'b0;
        w_spec_res1 = QNAN;
        if (w_a_nan || w_b_nan) begin
            w_spec_nv1 = w_a_snan || w_b_snan;
        end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
            w_spec_nv1 = 1'b1;
        end else if (w_a_inf) begin
            w_spec_res1 = {w_sa, EXP_ONES, {F{1'b0}}};
        end else if (w_b_inf) begin
            w_spec_res1 = {w_sb, EXP_ONES, {F{1'b0}}};
        end

        // Subnormals: hidden bit 0, exponent treated as 1.
        w_ma  = {(w_ea != '0), w_fa};
        w_mb  = {(w_eb != '0), w_fb};
        w_eam = (w_ea == '0) ? E'(1) : w_ea;
        w_ebm = (w_eb == '0) ? E'(1) : w_eb;

        w_a_ge = {w_eam, w_ma} >= {w_ebm, w_mb};
        w_sx   = w_a_ge ? w_sa  : w_sb;
        w_ex   = w_a_ge ? w_eam : w_ebm;
        w_mx   = w_a_ge ? w_ma  : w_mb;
        w_ey   = w_a_ge ? w_ebm : w_eam;
        w_my   = w_a_ge ? w_mb  : w_ma;
        w_d    = w_ex - w_ey;

        w_eff_sub = w_sa ^ w_sb;
        w_near    = w_eff_sub && (w_d <= E'(1));

        w_sh    = ({1'b0, w_d} >= N_E) ? SHW'(N) : SHW'(w_d);
        w_wide  = {w_my, 3'b000, {N{1'b0}}} >> w_sh;
        w_my_al = {w_wide[2*N-1:N+1], w_wide[N] | (|w_wide[N-1:0])};
    end

    logic            r2_sign, r2_sub, r2_near, r2_spec, r2_spec_nv;
    logic [E-1:0]    r2_ex;
    logic [P-1:0]    r2_mx;
    logic [N-1:0]    r2_my;
    logic [2:0]      r2_rm;
    logic [TAGW-1:0] r2_tag;
    logic [W-1:0]    r2_spec_res;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r2_v        <= 1'b0;
            r2_sign     <= 1'b0;
            r2_sub      <= 1'b0;
            r2_near     <= 1'b0;
            r2_spec     <= 1'b0;
            r2_spec_nv  <= 1'b0;
            r2_ex       <= '0;
            r2_mx       <= '0;
            r2_my       <= '0;
            r2_rm       <= '0;
            r2_tag      <= '0;
            r2_spec_res <= '0;
        end else if (w_en2) begin
            r2_v <= r1_v;
            if (r1_v) begin
                r2_sign     <= w_sx;
                r2_sub      <= w_eff_sub;
                r2_near     <= w_near;
                r2_spec     <= w_spec1;
                r2_spec_nv  <= w_spec_nv1;
                r2_ex       <= w_ex;
                r2_mx       <= w_mx;
                r2_my       <= w_my_al;
                r2_rm       <= w_rm1;
                r2_tag      <= r1_tag;
                r2_spec_res <= w_spec_res1;
            end
        end
    end

    // ---------------- S2: add/sub and normalise ----------------
    logic [N:0]     w_sum;
    logic [SHW-1:0] w_lz;
    logic [CW-1:0]  w_lim, w_lsh;
    logic [N-1:0]   w_mant2;
    logic [E:0]     w_exp2;
    logic           w_zero2;

    always_comb begin
        if (r2_sub) begin
            w_sum = {1'b0, r2_mx, 3'b000} - {1'b0, r2_my};
        end else begin
            w_sum = {1'b0, r2_mx, 3'b000} + {1'b0, r2_my};
        end
        w_zero2 = (w_sum == '0);

        w_lz = SHW'(N);
        for (int i = 0; i < N; i++) begin
            if (w_sum[i]) w_lz = SHW'(N - 1 - i);
        end

        // Left shift stops at exponent 1 so the result lands on a subnormal.
        w_lim = CW'(r2_ex) - CW'(1);
        w_lsh = '0;
        if (r2_near) begin
            w_lsh = (CW'(w_lz) > w_lim) ? w_lim : CW'(w_lz);
        end else if (!w_sum[N-1] && (r2_ex > E'(1))) begin
            w_lsh = CW'(1);
        end

        if (w_sum[N]) begin
            w_mant2 = {w_sum[N:2], |w_sum[1:0]};
            w_exp2  = {1'b0, r2_ex} + (E+1)'(1);
        end else begin
            w_mant2 = w_sum[N-1:0] << w_lsh;
            w_exp2  = (E+1)'(CW'(r2_ex) - w_lsh);
        end
    end

    logic            r3_sign, r3_sub, r3_zero, r3_spec, r3_spec_nv;
    logic [E:0]      r3_exp;
    logic [N-1:0]    r3_mant;
    logic [2:0]      r3_rm;
    logic [TAGW-1:0] r3_tag;
    logic [W-1:0]    r3_spec_res;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r3_v        <= 1'b0;
            r3_sign     <= 1'b0;
            r3_sub      <= 1'b0;
            r3_zero     <= 1'b0;
            r3_spec     <= 1'b0;
            r3_spec_nv  <= 1'b0;
            r3_exp      <= '0;
            r3_mant     <= '0;
            r3_rm       <= '0;
            r3_tag      <= '0;
            r3_spec_res <= '0;
        end else if (w_en3) begin
            r3_v <= r2_v;
            if (r2_v) begin
                r3_sign     <= r2_sign;
                r3_sub      <= r2_sub;
                r3_zero     <= w_zero2;
                r3_spec     <= r2_spec;
                r3_spec_nv  <= r2_spec_nv;
                r3_exp      <= w_exp2;
                r3_mant     <= w_mant2;
                r3_rm       <= r2_rm;
                r3_tag      <= r2_tag;
                r3_spec_res <= r2_spec_res;
            end
        end
    end

    // ---------------- S3: round, overflow, pack ----------------
    logic         w_lsb, w_g, w_rs, w_nx, w_rup, w_ovf, w_uf, w_use_max;
    logic [P:0]   w_sig_r;
    logic [P-1:0] w_sig;
    logic [E:0]   w_exp3;
    logic [W-1:0] w_res3;
    logic [4:0]   w_flags3;

    always_comb begin
        w_lsb = r3_mant[3];
        w_g   = r3_mant[2];
        w_rs  = |r3_mant[1:0];
        w_nx  = |r3_mant[2:0];
        case (r3_rm)
            RM_RTZ:  w_rup = 1'b0;
            RM_RDN:  w_rup = w_nx && r3_sign;
            RM_RUP:  w_rup = w_nx && !r3_sign;
            RM_RMM:  w_rup = w_g;
            default: w_rup = w_g && (w_rs || w_lsb);
        endcase

        w_sig_r = {1'b0, r3_mant[N-1:3]} + (P+1)'(w_rup);
        if (w_sig_r[P]) begin
            w_sig  = w_sig_r[P:1];
            w_exp3 = r3_exp + (E+1)'(1);
        end else begin
            w_sig  = w_sig_r[P-1:0];
            w_exp3 = r3_exp;
        end

        w_ovf     = w_sig[P-1] && (w_exp3 >= {1'b0, EXP_ONES});
        w_uf      = !w_sig[P-1] && w_nx;
        w_use_max = (r3_rm == RM_RTZ) || ((r3_rm == RM_RDN) && !r3_sign) ||
                    ((r3_rm == RM_RUP) && r3_sign);

        w_res3   = {r3_sign, (w_sig[P-1] ? w_exp3[E-1:0] : {E{1'b0}}), w_sig[F-1:0]};
        w_flags3 = {3'b000, w_uf, w_nx};
        if (r3_spec) begin
            w_res3   = r3_spec_res;
            w_flags3 = {r3_spec_nv, 4'b0000};
        end else if (r3_zero) begin
            // Exact cancellation is +0 except under RDN; like-signed zeros keep their sign.
            w_res3   = {(r3_sub ? (r3_rm == RM_RDN) : r3_sign), {(W-1){1'b0}}};
            w_flags3 = '0;
        end else if (w_ovf) begin
            w_res3   = w_use_max ? {r3_sign, EXP_ONES - E'(1), {F{1'b1}}}
                                 : {r3_sign, EXP_ONES, {F{1'b0}}};
            w_flags3 = 5'b00101;
        end
    end

    logic [W-1:0]    r_res;
    logic [4:0]      r_flags;
    logic [TAGW-1:0] r_tag;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_v <= 1'b0;
            r_res   <= '0;
            r_flags <= '0;
            r_tag   <= '0;
        end else if (w_en_o) begin
            r_out_v <= r3_v;
            if (r3_v) begin
                r_res   <= w_res3;
                r_flags <= w_flags3;
                r_tag   <= r3_tag;
            end
        end
    end

    assign out_valid_o = r_out_v;
    assign result_o    = r_res;
    assign fflags_o    = r_flags;
    assign tag_o       = r_tag;

endmodule

// File: tb/tb_fadd_pipe.sv
// Directed bench for fadd_pipe: scoreboard queue filled at input transfer,
// drained and compared by an output monitor; includes stall and reset cases.
module tb_fadd_pipe;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] a_i, b_i;
    logic        sub_i;
    logic [2:0]  RM_i;
    logic [3:0]  tag_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic [4:0]  fflags_o;
    logic [3:0]  tag_o;

    fadd_pipe #(.EXPWIDTH(8), .PRECISION(24), .TAGW(4)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .a_i        (a_i),
        .b_i        (b_i),
        .sub_i      (sub_i),
        .RM_i       (RM_i),
        .tag_i      (tag_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .result_o   (result_o),
        .fflags_o   (fflags_o),
        .tag_o      (tag_o)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0]  tag;
        logic [4:0]  fl;
        logic [31:0] res;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    logic [31:0] fv[0:9];

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, expv);
        end
    endtask

    task automatic monitor();
        logic        prev_stall;
        logic [31:0] h_res;
        logic [4:0]  h_fl;
        logic [3:0]  h_tag;
        exp_t        e;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 64'(out_valid_o), 64'(1));
                    chk("hold_result", 64'(result_o), 64'(h_res));
                    chk("hold_flags", 64'(fflags_o), 64'(h_fl));
                    chk("hold_tag", 64'(tag_o), 64'(h_tag));
                end
                if (out_valid_o && out_ready_i) begin
                    n_out++;
                    if (q.size() == 0) begin
                        chk("unexpected_output", 64'(1), 64'(0));
                    end else begin
                        e = q.pop_front();
                        chk("result", 64'(result_o), 64'(e.res));
                        chk("fflags", 64'(fflags_o), 64'(e.fl));
                        chk("tag", 64'(tag_o), 64'(e.tag));
                    end
                end
                prev_stall = out_valid_o && !out_ready_i;
                h_res = result_o;
                h_fl  = fflags_o;
                h_tag = tag_o;
            end
        end
    endtask

    // Offer one op; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [2:0] rm, input logic [3:0] tg,
                        input logic [31:0] er, input logic [4:0] ef, output bit waited);
        int   k;
        exp_t e;
        waited     = 1'b0;
        in_valid_i = 1'b1;
        a_i = a; b_i = b; sub_i = s; RM_i = rm; tag_i = tg;
        k = 0;
        forever begin
            @(negedge clk_i);
            if (in_ready_o) break;
            waited = 1'b1;
            k++;
            if (k > 100) break;
        end
        if (k > 100) begin
            chk("in_ready_timeout", 64'(0), 64'(1));
        end else begin
            @(posedge clk_i);
            e.tag = tg; e.fl = ef; e.res = er;
            q.push_back(e);
        end
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q.size() != 0 || out_valid_o) && k < 200) begin
            @(posedge clk_i);
            k++;
        end
        #1;
        chk("drain_queue_empty", 64'(q.size()), 64'(0));
    endtask

    bit w;
    bit stall_seen;
    int out_base;

    initial begin
        fork
            begin
                #200000;
                $display("FAIL watchdog expired");
                $fatal(1, "watchdog");
            end
        join_none

        fv[1] = 32'h3F800000; fv[2] = 32'h40000000; fv[3] = 32'h40400000;
        fv[4] = 32'h40800000; fv[5] = 32'h40A00000; fv[6] = 32'h40C00000;
        fv[7] = 32'h40E00000; fv[8] = 32'h41000000; fv[9] = 32'h41100000;
        fv[0] = 32'h00000000;

        rst_ni = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b1;
        a_i = 32'h3F800000; b_i = 32'h3F800000; sub_i = 1'b0; RM_i = 3'd0; tag_i = 4'd9;
        fork monitor(); join_none

        // Reset holds the output idle even with an op offered.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i); #1;
            chk("rst_out_valid", 64'(out_valid_o), 64'(0));
        end
        chk("rst_result", 64'(result_o), 64'(0));
        chk("rst_fflags", 64'(fflags_o), 64'(0));
        chk("rst_tag", 64'(tag_o), 64'(0));
        in_valid_i = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("in_ready_after_reset", 64'(in_ready_o), 64'(1));
        chk("out_valid_after_reset", 64'(out_valid_o), 64'(0));

        // Latency: accepted at edge N, valid after edge N+3.
        send(32'h3F800000, 32'h40000000, 1'b0, 3'd0, 4'd5, 32'h40400000, 5'h00, w);
        chk("lat_n", 64'(out_valid_o), 64'(0));
        @(posedge clk_i); #1; chk("lat_n1", 64'(out_valid_o), 64'(0));
        @(posedge clk_i); #1; chk("lat_n2", 64'(out_valid_o), 64'(0));
        @(posedge clk_i); #1; chk("lat_n3", 64'(out_valid_o), 64'(1));
        drain();

        // Directed arithmetic cases, streamed back to back.
        send(32'h3F800000, 32'h3F800000, 1'b1, 3'd0, 4'd1, 32'h00000000, 5'h00, w);
        send(32'h3F800000, 32'h3F800000, 1'b1, 3'd2, 4'd2, 32'h80000000, 5'h00, w);
        send(32'h3F800000, 32'h33800000, 1'b0, 3'd0, 4'd3, 32'h3F800000, 5'h01, w);
        send(32'h3F800000, 32'h33800000, 1'b0, 3'd3, 4'd4, 32'h3F800001, 5'h01, w);
        send(32'h3F800000, 32'h33800000, 1'b0, 3'd1, 4'd5, 32'h3F800000, 5'h01, w);
        send(32'h3F800000, 32'h33800000, 1'b0, 3'd4, 4'd6, 32'h3F800001, 5'h01, w);
        send(32'h3F800000, 32'h33800000, 1'b0, 3'd5, 4'd7, 32'h3F800000, 5'h01, w);
        send(32'h3F800001, 32'h33800000, 1'b0, 3'd0, 4'd8, 32'h3F800002, 5'h01, w);
        send(32'h7F800000, 32'hFF800000, 1'b0, 3'd0, 4'd9, 32'h7FC00000, 5'h10, w);
        send(32'h7F800001, 32'h3F800000, 1'b0, 3'd0, 4'd10, 32'h7FC00000, 5'h10, w);
        send(32'h7FC00001, 32'h3F800000, 1'b0, 3'd0, 4'd11, 32'h7FC00000, 5'h00, w);
        send(32'h7F800000, 32'h3F800000, 1'b0, 3'd0, 4'd12, 32'h7F800000, 5'h00, w);
        send(32'h3F800000, 32'h7F800000, 1'b1, 3'd0, 4'd13, 32'hFF800000, 5'h00, w);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd0, 4'd14, 32'h7F800000, 5'h05, w);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd1, 4'd15, 32'h7F7FFFFF, 5'h05, w);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd2, 4'd0, 32'h7F7FFFFF, 5'h05, w);
        send(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'd3, 4'd1, 32'hFF7FFFFF, 5'h05, w);
        send(32'h00000001, 32'h00000001, 1'b0, 3'd0, 4'd2, 32'h00000002, 5'h00, w);
        send(32'h00800000, 32'h00000001, 1'b1, 3'd0, 4'd3, 32'h007FFFFF, 5'h00, w);
        send(32'h80000000, 32'h80000000, 1'b0, 3'd3, 4'd4, 32'h80000000, 5'h00, w);
        send(32'h3F800000, 32'hBF800000, 1'b0, 3'd2, 4'd5, 32'h80000000, 5'h00, w);
        send(32'h40000000, 32'h3F400000, 1'b1, 3'd0, 4'd6, 32'h3FA00000, 5'h00, w);
        send(32'h3F800000, 32'h3F7FFFFF, 1'b1, 3'd0, 4'd7, 32'h33800000, 5'h00, w);
        drain();

        // Backpressure: 8 ops, consumer stalls for cycles 4-9.
        stall_seen = 1'b0;
        out_base   = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(fv[i+1], 32'h3F800000, 1'b0, 3'd0, 4'(i), fv[i+2], 5'h00, w);
                    if (w) stall_seen = 1'b1;
                end
            end
            begin
                repeat (4) @(posedge clk_i);
                #1 out_ready_i = 1'b0;
                repeat (6) @(posedge clk_i);
                #1 out_ready_i = 1'b1;
            end
        join
        drain();
        chk("in_ready_fell", 64'(stall_seen), 64'(1));
        chk("bp_output_count", 64'(n_out - out_base), 64'(8));

        // Reset while stalled discards in-flight ops.
        out_ready_i = 1'b0;
        send(32'h3F800000, 32'h3F800000, 1'b0, 3'd0, 4'd1, 32'h40000000, 5'h00, w);
        send(32'h3F800000, 32'h40000000, 1'b0, 3'd0, 4'd2, 32'h40400000, 5'h00, w);
        repeat (4) @(posedge clk_i);
        #1;
        chk("stalled_valid", 64'(out_valid_o), 64'(1));
        rst_ni = 1'b0;
        q.delete();
        #1;
        chk("midrst_out_valid", 64'(out_valid_o), 64'(0));
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        out_ready_i = 1'b1;
        out_base = n_out;
        repeat (6) begin
            @(posedge clk_i); #1;
            chk("post_rst_idle", 64'(out_valid_o), 64'(0));
        end
        chk("post_rst_no_output", 64'(n_out - out_base), 64'(0));
        chk("post_rst_in_ready", 64'(in_ready_o), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fadd_pipe.md
Name: fadd_pipe

Overview:
- Fully pipelined, parametrised IEEE-754-style floating-point adder/subtractor with valid/ready handshake on both sides.
- Successor to the single-stage far/near-path front end. Adds complete rounding (all five RISC-V modes), subtraction via an op bit, a tag sideband, exception flags and backpressure-safe stalling.
- Sits in the tensor-core FP datapath between the operand collector and the writeback arbiter.

Parameters:
- EXPWIDTH, 8, exponent field width.
- PRECISION, 24, significand precision including the hidden bit. Fraction field is PRECISION-1 bits. Word width W = EXPWIDTH+PRECISION.
- TAGW, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  operation offered
- in_ready_o  out  1  block accepts the operation this cycle
- a_i  in  W  operand A: {sign, exp, frac}
- b_i  in  W  operand B
- sub_i  in  1  1 = A-B, 0 = A+B
- RM_i  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 are treated as RNE
- tag_i  in  TAGW  sideband, returned unchanged
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- result_o  out  W  rounded result
- fflags_o  out  5  {NV, DZ, OF, UF, NX}; DZ is always 0
- tag_o  out  TAGW  tag of the result

Behaviour:
- Reset (async on rst_ni low, released synchronously to clk_i):
  - all stage valids are 0; out_valid_o=0, result_o=0, fflags_o=0, tag_o=0.
  - in_ready_o=1 one cycle after reset release.
  - in-flight operations are discarded; reset mid-stall loses them without any output.
- Pipeline, 3 stages:
  - S1: unpack, special-case detect, effective-op sign (b sign XOR sub_i), exponent diff, far/near path select. Far path when |expdiff|>1 or the effective op is an addition; near otherwise. Alignment shift uses guard/round/sticky.
  - S2: significand add/sub. Near path uses a leading-zero count and left normalise, clamped so the exponent never drops below 1 (subnormal output).
  - S3: rounding, overflow/underflow detection, pack, flags.
- Latency is exactly 3 cycles with no stalls: accepted at edge N, out_valid_o high after edge N+3.
- Handshake:
  - Transfer occurs when valid&&ready are both high at the rising edge.
  - Each stage advances when it is empty or the next stage advances. in_ready_o = !S1_valid || S1_advances. No combinational path from in_valid_i to in_ready_o.
  - Throughput is 1 op/cycle when out_ready_i=1.
  - Output holds stable (result_o, fflags_o, tag_o) while out_valid_o && !out_ready_i.
- Arithmetic:
  - Subnormal inputs are handled (hidden bit 0, exp treated as 1).
  - Exact zero sum gives +0, except -0 under RDN. (-0)+(-0) gives -0 in every mode.
  - Any NaN input gives canonical qNaN: sign 0, exp all-ones, frac MSB 1, rest 0.
  - Signalling-NaN input or Inf-Inf sets NV.
  - Inf+finite gives that Inf with no flags.
  - Overflow sets OF|NX. Result is Inf, or max-finite under RTZ, RDN with a positive result, or RUP with a negative result.
  - UF is set when the result is tiny after rounding and inexact.
  - NX is set on any rounding loss.
- tag_o follows its operation through all stages.

Test Plan:
- Reset and latency: hold rst_ni=0 with in_valid_i=1 -> out_valid_o=0 throughout. Release, then drive a=3F800000, b=40000000, RNE, tag=5 -> 3 cycles later result_o=40400000, fflags_o=0, tag_o=5.
- Cancellation: a=3F800000, b=3F800000, sub_i=1 -> RNE gives 00000000; RDN gives 80000000; fflags_o=0 in both.
- Rounding: a=3F800000, b=33800000 -> RNE gives 3F800000 with NX; RUP gives 3F800001 with NX; RTZ gives 3F800000 with NX.
- Specials:
  - 7F800000 + FF800000 -> 7FC00000, NV.
  - 7F800001 + 3F800000 -> 7FC00000, NV.
  - 7F7FFFFF + 7F7FFFFF -> RNE gives 7F800000 with OF|NX; RTZ gives 7F7FFFFF with OF|NX.
- Subnormal: 00000001 + 00000001 -> 00000002 with no flags; 00800000 - 00000001 -> 007FFFFF with no flags.
- Backpressure: stream 8 back-to-back ops with tags 0-7, hold out_ready_i=0 for cycles 4-9 -> in_ready_o falls once the pipe is full, no op is lost or duplicated, results emerge in tag order 0-7, and output stays stable while stalled.
